ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Consumer end of the ID/EX pipeline register: decodes the EX control bundle, runs the ALU,
//  and holds an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers.
//  Registers results into the EX/MEM boundary.
//  Raises Stall_EX so that ID/EX and the upstream stages hold while mult/div iterates.
// PARAMETERS
//  WIDTH    32  datapath width (only 32 supported)
//  MD_ITER  32  iterations per multu/divu
// PORTS
//  Clk            in   1   rising-edge clock
//  Rst            in   1   asynchronous reset, active-low
//  WB_EX          in   2   [1]=RegWrite [0]=MemtoReg
//  MEM_EX         in   2   [1]=MemRead [0]=MemWrite
//  EX_EX          in   4   [3]=RegDst [2:1]=ALUOp [0]=ALUSrc
//  Rt_EX, Rd_EX   in   5   destination candidates
//  Shamt_EX       in   6   shift amount (bits [4:0] used)
//  Funct_EX       in   6   R-type function code
//  RD1_EX, RD2_EX in   32  register operands A, B
//  Ext_Immed_EX   in   32  sign-extended immediate
//  WB_MEM         out  2   registered WB control
//  MEM_MEM        out  2   registered MEM control
//  ALUOut_MEM     out  32  registered ALU / HI / LO result
//  WriteData_MEM  out  32  registered RD2_EX (store data)
//  WriteReg_MEM   out  5   registered dest: RegDst ? Rd_EX : Rt_EX
//  Stall_EX       out  1   combinational: hold ID/EX and earlier stages
//  Busy           out  1   registered: state == BUSY
// BEHAVIOUR
//  Reset (Rst=0, async): all outputs, HI, LO, count = 0; state = IDLE.
//  Operand B = ALUSrc ? Ext_Immed_EX : RD2_EX.
//  ALUOp decode:
//   00 add; 01 sub; 11 OR; 10 R-type by Funct:
//   20 add, 22 sub, 24 and, 25 or, 2A slt (signed, result 0/1),
//   00 sll B, 02 srl B (by Shamt[4:0]), 10 mfhi, 12 mflo,
//   19 multu, 1B divu; any other Funct -> result 0.
//  Width rules: add/sub wrap mod 2^32, no overflow trap.
//  Single-cycle ops: EX/MEM captures all fields on every edge where Stall_EX=0, latency 1.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: if ALUOp=10 and Funct in {19,1B}: load operands, count=0, ->BUSY;
//         Stall_EX=1 this cycle; EX/MEM loads a bubble.
//   BUSY: one shift-add (multu) or restoring-subtract (divu) step per cycle.
//         At count=MD_ITER-1: write HI/LO, ->DONE. Stall_EX=1 throughout.
//   DONE: Stall_EX=0; the mult/div retires into EX/MEM as a bubble (it writes no GPR);
//         -> IDLE. DONE blocks re-triggering by the same instruction.
//  Bubble = WB_MEM=0, MEM_MEM=0, ALUOut_MEM=0, WriteData_MEM=0, WriteReg_MEM=0.
//  Total occupancy of multu/divu: 34 cycles, of which Stall_EX is high for 33.
//  multu: {HI,LO} = A*B (64-bit unsigned). divu: LO = A/B, HI = A%B.
//  Divide by zero: LO = 32'hFFFF_FFFF, HI = A; still takes 32 iterations.
//  mfhi/mflo directly after DONE read the updated HI/LO (no hazard).
//  Reset asserted mid-BUSY: iteration is abandoned, HI/LO = 0, state = IDLE.
//  Inputs must be held stable by ID/EX while Stall_EX=1; operands are latched at IDLE->BUSY.
// TESTING
//  1. Reset low, then add: RD1=100, RD2=200, ALUOp=10, Funct=20, RegDst=1, Rd=2, WB=2'b10.
//     -> next edge: ALUOut_MEM=300, WriteReg_MEM=2, WB_MEM=2'b10.
//  2. ALUSrc=1, ALUOp=00, RD1=5, Imm=32'hFFFF_FFFF, RegDst=0, Rt=3.
//     -> ALUOut_MEM=4, WriteReg_MEM=3; slt with -1 vs 1 -> ALUOut_MEM=1.
//  3. multu 0xFFFF_FFFF x 2, then mfhi, then mflo.
//     -> Stall_EX high 33 cycles, Busy high 32 cycles; mfhi yields 1, mflo yields 0xFFFF_FFFE.
//  4. divu 100 / 7, then mflo/mfhi -> 14, 2. divu 9 / 0 -> LO=FFFF_FFFF, HI=9.
//  5. Drop Rst at BUSY count=10.
//     -> all outputs 0, Stall_EX=0 and Busy=0 immediately; next add completes normally.
//  6. During a stall, MEM_EX=2'b01 present.
//     -> MEM_MEM stays 0 until the instruction actually advances.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage with ALU, iterative multu/divu unit, HI/LO, and EX/MEM register.
module ex_stage #(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       WB_EX,
  input  logic [1:0]       MEM_EX,
  input  logic [3:0]       EX_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rd_EX,
  input  logic [5:0]       Shamt_EX,
  input  logic [5:0]       Funct_EX,
  input  logic [WIDTH-1:0] RD1_EX,
  input  logic [WIDTH-1:0] RD2_EX,
  input  logic [WIDTH-1:0] Ext_Immed_EX,
  output logic [1:0]       WB_MEM,
  output logic [1:0]       MEM_MEM,
  output logic [WIDTH-1:0] ALUOut_MEM,
  output logic [WIDTH-1:0] WriteData_MEM,
  output logic [4:0]       WriteReg_MEM,
  output logic             Stall_EX,
  output logic             Busy
);
  localparam int CW = $clog2(MD_ITER);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   w_b, w_res, r_hi, r_lo, r_m;
  logic [2*WIDTH-1:0] r_acc, w_step;
  logic [WIDTH:0]     w_sum, w_sh, w_diff;
  logic [CW-1:0]      r_count;
  logic               r_div, w_is_md, w_last, w_bubble, w_unused;
  assign w_unused = Shamt_EX[5];
  assign w_b      = EX_EX[0] ? Ext_Immed_EX : RD2_EX;
  assign w_is_md  = EX_EX[2:1] == 2'b10 && (Funct_EX == 6'h19 || Funct_EX == 6'h1B);
  assign w_last   = r_count == CW'(MD_ITER - 1);
  assign Stall_EX = Rst && ((r_state == IDLE && w_is_md) || r_state == BUSY);
  assign Busy     = r_state == BUSY;
  // the mult/div instruction never reaches EX/MEM as a real write
  assign w_bubble = w_is_md || r_state != IDLE;
  always_comb begin
    w_res = '0;
    case (EX_EX[2:1])
      2'b00: w_res = RD1_EX + w_b;
      2'b01: w_res = RD1_EX - w_b;
      2'b11: w_res = RD1_EX | w_b;
      default:
        case (Funct_EX)
          6'h20: w_res = RD1_EX + w_b;
          6'h22: w_res = RD1_EX - w_b;
          6'h24: w_res = RD1_EX & w_b;
          6'h25: w_res = RD1_EX | w_b;
          6'h2A: w_res = {{(WIDTH-1){1'b0}}, $signed(RD1_EX) < $signed(w_b)};
          6'h00: w_res = w_b << Shamt_EX[4:0];
          6'h02: w_res = w_b >> Shamt_EX[4:0];
          6'h10: w_res = r_hi;
          6'h12: w_res = r_lo;
          default: w_res = '0;
        endcase
    endcase
  end
  // r_acc holds {HI,LO} partial product for multu, {remainder,quotient} for divu
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : {WIDTH{1'b0}})};
  assign w_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff = w_sh - {1'b0, r_m};
  assign w_step = !r_div     ? {w_sum, r_acc[WIDTH-1:1]} :
                  w_diff[WIDTH] ? {w_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                  {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_is_md ? BUSY : IDLE;
      BUSY:    w_next = w_last ? DONE : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= IDLE;
      r_hi          <= '0;
      r_lo          <= '0;
      r_m           <= '0;
      r_acc         <= '0;
      r_count       <= '0;
      r_div         <= 1'b0;
      WB_MEM        <= '0;
      MEM_MEM       <= '0;
      ALUOut_MEM    <= '0;
      WriteData_MEM <= '0;
      WriteReg_MEM  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_is_md) begin
        r_div   <= Funct_EX == 6'h1B;
        r_m     <= Funct_EX == 6'h1B ? w_b : RD1_EX;
        r_acc   <= {{WIDTH{1'b0}}, (Funct_EX == 6'h1B ? RD1_EX : w_b)};
        r_count <= '0;
      end else if (r_state == BUSY) begin
        r_acc   <= w_step;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_hi <= w_step[2*WIDTH-1:WIDTH];
          r_lo <= w_step[WIDTH-1:0];
        end
      end
      WB_MEM        <= w_bubble ? 2'b00 : WB_EX;
      MEM_MEM       <= w_bubble ? 2'b00 : MEM_EX;
      ALUOut_MEM    <= w_bubble ? '0 : w_res;
      WriteData_MEM <= w_bubble ? '0 : RD2_EX;
      WriteReg_MEM  <= w_bubble ? 5'd0 : (EX_EX[3] ? Rd_EX : Rt_EX);
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ALU ops, multu/divu timing and results, and async reset.
module tb_ex_stage;
  logic        Clk = 1'b0, Rst;
  logic [1:0]  WB_EX, MEM_EX, WB_MEM, MEM_MEM;
  logic [3:0]  EX_EX;
  logic [4:0]  Rt_EX, Rd_EX, WriteReg_MEM;
  logic [5:0]  Shamt_EX, Funct_EX;
  logic [31:0] RD1_EX, RD2_EX, Ext_Immed_EX, ALUOut_MEM, WriteData_MEM;
  logic        Stall_EX, Busy;
  int n_checks = 0, n_fail = 0;
  ex_stage dut (
    .Clk(Clk), .Rst(Rst), .WB_EX(WB_EX), .MEM_EX(MEM_EX), .EX_EX(EX_EX),
    .Rt_EX(Rt_EX), .Rd_EX(Rd_EX), .Shamt_EX(Shamt_EX), .Funct_EX(Funct_EX),
    .RD1_EX(RD1_EX), .RD2_EX(RD2_EX), .Ext_Immed_EX(Ext_Immed_EX),
    .WB_MEM(WB_MEM), .MEM_MEM(MEM_MEM), .ALUOut_MEM(ALUOut_MEM),
    .WriteData_MEM(WriteData_MEM), .WriteReg_MEM(WriteReg_MEM),
    .Stall_EX(Stall_EX), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic [3:0]  ex;
    logic [5:0]  fn;
    logic [5:0]  sh;
    logic [31:0] a, b, imm, exp;
  } vec_t;
  task automatic set_in(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] ex,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] sh,
                        input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm);
    WB_EX = wb; MEM_EX = mem; EX_EX = ex; Rt_EX = rt; Rd_EX = rd;
    Shamt_EX = sh; Funct_EX = fn; RD1_EX = a; RD2_EX = b; Ext_Immed_EX = imm;
  endtask
  task automatic step;
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic test_reset;
    Rst = 1'b0;
    set_in(2'b11, 2'b11, 4'b1100, 5'd1, 5'd2, 6'd0, 6'h19, 32'd5, 32'd6, 32'd0);
    @(negedge Clk);
    n_checks++;
    if ({WB_MEM, MEM_MEM, ALUOut_MEM, WriteData_MEM, WriteReg_MEM, Stall_EX, Busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wb=%b mem=%b alu=%h wd=%h wr=%0d stall=%b busy=%b, want all 0",
               WB_MEM, MEM_MEM, ALUOut_MEM, WriteData_MEM, WriteReg_MEM, Stall_EX, Busy);
    end
  endtask
  task automatic test_add;
    set_in(2'b10, 2'b00, 4'b1100, 5'd7, 5'd2, 6'd0, 6'h20, 32'd100, 32'd200, 32'd0);
    Rst = 1'b1;
    step();
    n_checks++;
    if (ALUOut_MEM !== 32'd300 || WriteReg_MEM !== 5'd2 || WB_MEM !== 2'b10 || WriteData_MEM !== 32'd200) begin
      n_fail++;
      $display("FAIL add: got alu=%0d wr=%0d wb=%b wd=%0d, want 300 2 10 200",
               ALUOut_MEM, WriteReg_MEM, WB_MEM, WriteData_MEM);
    end
  endtask
  task automatic test_alu;
    vec_t v[12];
    logic [4:0] exp_wr;
    v[0]  = '{4'b0001, 6'h00, 6'd0,  32'd5,          32'd9,          32'hFFFF_FFFF, 32'd4};
    v[1]  = '{4'b1100, 6'h2A, 6'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,         32'd1};
    v[2]  = '{4'b1100, 6'h2A, 6'd0,  32'd1,          32'hFFFF_FFFF,  32'd0,         32'd0};
    v[3]  = '{4'b1100, 6'h22, 6'd0,  32'd10,         32'd3,          32'd0,         32'd7};
    v[4]  = '{4'b1100, 6'h22, 6'd0,  32'd0,          32'd1,          32'd0,         32'hFFFF_FFFF};
    v[5]  = '{4'b1100, 6'h24, 6'd0,  32'h0000_F0F0,  32'h0000_FF00,  32'd0,         32'h0000_F000};
    v[6]  = '{4'b1100, 6'h25, 6'd0,  32'h0000_000F,  32'h0000_00F0,  32'd0,         32'h0000_00FF};
    v[7]  = '{4'b1100, 6'h00, 6'd31, 32'd0,          32'd1,          32'd0,         32'h8000_0000};
    v[8]  = '{4'b1100, 6'h02, 6'd36, 32'd0,          32'h8000_0000,  32'd0,         32'h0800_0000};
    v[9]  = '{4'b1100, 6'h3F, 6'd0,  32'd5,          32'd6,          32'd0,         32'd0};
    v[10] = '{4'b0010, 6'h00, 6'd0,  32'd20,         32'd5,          32'd0,         32'd15};
    v[11] = '{4'b0111, 6'h00, 6'd0,  32'h0000_00F0,  32'd0,          32'h0000_000F, 32'h0000_00FF};
    for (int i = 0; i < 12; i++) begin
      set_in(2'b10, 2'b10, v[i].ex, 5'd3, 5'd9, v[i].sh, v[i].fn, v[i].a, v[i].b, v[i].imm);
      exp_wr = v[i].ex[3] ? 5'd9 : 5'd3;
      step();
      n_checks++;
      if (ALUOut_MEM !== v[i].exp || WriteReg_MEM !== exp_wr || WriteData_MEM !== v[i].b || MEM_MEM !== 2'b10) begin
        n_fail++;
        $display("FAIL alu_vec%0d: got alu=%h wr=%0d wd=%h mem=%b, want %h %0d %h 10",
                 i, ALUOut_MEM, WriteReg_MEM, WriteData_MEM, MEM_MEM, v[i].exp, exp_wr, v[i].b);
      end
    end
  endtask
  task automatic test_md(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls = 0, busys = 0;
    bit leak = 1'b0;
    set_in(2'b10, 2'b01, 4'b1100, 5'd3, 5'd4, 6'd0, fn, a, b, 32'd0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall_EX) break;
      stalls++;
      if (Busy) busys++;
      if (i > 0 && (MEM_MEM !== 2'b00 || WB_MEM !== 2'b00)) leak = 1'b1;
      step();
    end
    n_checks++;
    if (stalls != 33 || busys != 32) begin
      n_fail++;
      $display("FAIL %s_timing: got stall=%0d busy=%0d cycles, want 33 32", name, stalls, busys);
    end
    n_checks++;
    if (leak || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: got leak=%b busy=%b, want 0 0", name, leak, Busy);
    end
    @(posedge Clk);
    #1 set_in(2'b10, 2'b00, 4'b1100, 5'd0, 5'd5, 6'd0, 6'h10, 32'd0, 32'd0, 32'd0);
    @(negedge Clk);
    n_checks++;
    if (WB_MEM !== 2'b00 || MEM_MEM !== 2'b00 || ALUOut_MEM !== 32'd0 || Stall_EX !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_retire: got wb=%b mem=%b alu=%h stall=%b, want 00 00 0 0",
               name, WB_MEM, MEM_MEM, ALUOut_MEM, Stall_EX);
    end
    step();
    n_checks++;
    if (ALUOut_MEM !== exp_hi || WB_MEM !== 2'b10 || WriteReg_MEM !== 5'd5) begin
      n_fail++;
      $display("FAIL %s_mfhi: got alu=%h wb=%b wr=%0d, want %h 10 5", name, ALUOut_MEM, WB_MEM, WriteReg_MEM, exp_hi);
    end
    set_in(2'b10, 2'b00, 4'b1100, 5'd0, 5'd6, 6'd0, 6'h12, 32'd0, 32'd0, 32'd0);
    step();
    n_checks++;
    if (ALUOut_MEM !== exp_lo || WriteReg_MEM !== 5'd6) begin
      n_fail++;
      $display("FAIL %s_mflo: got alu=%h wr=%0d, want %h 6", name, ALUOut_MEM, WriteReg_MEM, exp_lo);
    end
  endtask
  task automatic test_reset_mid_busy;
    set_in(2'b10, 2'b01, 4'b1100, 5'd3, 5'd4, 6'd0, 6'h19, 32'hFFFF_FFFF, 32'd3, 32'd0);
    for (int i = 0; i < 11; i++) step();
    n_checks++;
    if (Busy !== 1'b1 || Stall_EX !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got busy=%b stall=%b, want 1 1", Busy, Stall_EX);
    end
    Rst = 1'b0;
    #1;
    n_checks++;
    if ({WB_MEM, MEM_MEM, ALUOut_MEM, WriteData_MEM, WriteReg_MEM, Stall_EX, Busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got alu=%h stall=%b busy=%b wb=%b, want all 0",
               ALUOut_MEM, Stall_EX, Busy, WB_MEM);
    end
    set_in(2'b10, 2'b00, 4'b1100, 5'd0, 5'd8, 6'd0, 6'h20, 32'd7, 32'd8, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    step();
    n_checks++;
    if (ALUOut_MEM !== 32'd15 || WriteReg_MEM !== 5'd8 || Stall_EX !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_add: got alu=%0d wr=%0d stall=%b, want 15 8 0", ALUOut_MEM, WriteReg_MEM, Stall_EX);
    end
    set_in(2'b10, 2'b00, 4'b1100, 5'd0, 5'd8, 6'd0, 6'h10, 32'd0, 32'd0, 32'd0);
    step();
    n_checks++;
    if (ALUOut_MEM !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_hi: got alu=%h, want 0", ALUOut_MEM);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_alu();
    test_md("multu", 32'hFFFF_FFFF, 32'd2, 6'h19, 32'd1, 32'hFFFF_FFFE);
    test_md("divu", 32'd100, 32'd7, 6'h1B, 32'd2, 32'd14);
    test_md("divu0", 32'd9, 32'd0, 6'h1B, 32'd9, 32'hFFFF_FFFF);
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
